rgb2ycbcr_pipe: RTL and testbench

- Streaming colour-space converter directly downstream of the bilinear/neighbour demosaic stage.
- Consumes one RGB888 pixel per valid cycle (oR/oG/oB/oValid of the demosaic).
- Produces ITU-R BT.601 full-range YCbCr444 through a fixed 3-stage pipeline.
- Counts pixels per frame and flags the last pixel so downstream stages (scaler, frame writer) can frame-align.

---
 rtl/rgb2ycbcr_pipe.sv | 142 ++++++++++++++
 tb/tb_rgb2ycbcr_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: RGB888 -> BT.601 full-range YCbCr444 converter with per-frame pixel count.
// Latency: 3 cycles from an accepted iValid to the matching oValid.
// Backpressure: none; the pipeline advances every cycle and bubbles pass through uncounted.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   iR/iG/iB, iValid     input pixel and its qualifier
//   oY/oCb/oCr, oValid   converted pixel (holds last value when oValid=0)
//   oDone                one-cycle pulse with the last pixel of each width*height frame
//   oLumaSum             frame luma total, only when LUMA_SUM_EN is defined
module rgb2ycbcr_pipe #(
    parameter int width  = 320,
    parameter int height = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    input  logic        iValid,
    output logic [7:0]  oY,
    output logic [7:0]  oCb,
    output logic [7:0]  oCr,
    output logic        oValid,
`ifdef LUMA_SUM_EN
    output logic [31:0] oLumaSum,
`endif
    output logic        oDone
);

    localparam logic [31:0] LAST_PIX = 32'(width * height - 1);

    // Zero-extend inputs into the signed product domain.
    logic signed [17:0] r_s, g_s, b_s;
    assign r_s = {10'd0, iR};
    assign g_s = {10'd0, iG};
    assign b_s = {10'd0, iB};

    // Stage 1: nine Q8 products.
    logic               v1_q;
    logic signed [17:0] yr_q, yg_q, yb_q;
    logic signed [17:0] br_q, bg_q, bb_q;
    logic signed [17:0] rr_q, rg_q, rb_q;

    // Stage 2: rounded sums. 18 bits suffice: Y peaks at 65408, chroma stays within +/-32768.
    logic               v2_q;
    logic signed [17:0] ysum_q, cbsum_q, crsum_q;

    // Stage 3 combinational: floor shift, chroma offset, clamp.
    logic signed [17:0] y_sh, cb_sh, cr_sh;
    logic [7:0]         y_d, cb_d, cr_d;

    logic [31:0]        cnt_q;
`ifdef LUMA_SUM_EN
    logic [31:0]        acc_q;
`endif

    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    always_comb begin
        y_sh  = ysum_q  >>> 8;
        cb_sh = (cbsum_q >>> 8) + 18'sd128;
        cr_sh = (crsum_q >>> 8) + 18'sd128;
        y_d   = clamp8(y_sh);
        // Saturated blue/red land on 256 after the offset, hence the clamp.
        cb_d  = clamp8(cb_sh);
        cr_d  = clamp8(cr_sh);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            yr_q    <= '0; yg_q <= '0; yb_q <= '0;
            br_q    <= '0; bg_q <= '0; bb_q <= '0;
            rr_q    <= '0; rg_q <= '0; rb_q <= '0;
            v2_q    <= 1'b0;
            ysum_q  <= '0;
            cbsum_q <= '0;
            crsum_q <= '0;
            oY      <= '0;
            oCb     <= '0;
            oCr     <= '0;
            oValid  <= 1'b0;
            oDone   <= 1'b0;
            cnt_q   <= '0;
`ifdef LUMA_SUM_EN
            acc_q    <= '0;
            oLumaSum <= '0;
`endif
        end else begin
            // Stage 1
            v1_q <= iValid;
            yr_q <= r_s * 18'sd77;
            yg_q <= g_s * 18'sd150;
            yb_q <= b_s * 18'sd29;
            br_q <= r_s * (-18'sd43);
            bg_q <= g_s * (-18'sd85);
            bb_q <= b_s * 18'sd128;
            rr_q <= r_s * 18'sd128;
            rg_q <= g_s * (-18'sd107);
            rb_q <= b_s * (-18'sd21);

            // Stage 2: +128 so the later floor shift rounds to nearest.
            v2_q    <= v1_q;
            ysum_q  <= yr_q + yg_q + yb_q + 18'sd128;
            cbsum_q <= br_q + bg_q + bb_q + 18'sd128;
            crsum_q <= rr_q + rg_q + rb_q + 18'sd128;

            // Stage 3: outputs only update on valid slots.
            oValid <= v2_q;
            oDone  <= 1'b0;
            if (v2_q) begin
                oY  <= y_d;
                oCb <= cb_d;
                oCr <= cr_d;
                if (cnt_q == LAST_PIX) begin
                    oDone <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 32'd1;
                end
`ifdef LUMA_SUM_EN
                // Frame total includes the last pixel; accumulator restarts for the next frame.
                if (cnt_q == LAST_PIX) begin
                    oLumaSum <= acc_q + {24'd0, y_d};
                    acc_q    <= '0;
                end else begin
                    acc_q    <= acc_q + {24'd0, y_d};
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
module tb_rgb2ycbcr_pipe;

    localparam int W = 4;
    localparam int H = 2;
    localparam int FRAME = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  iR, iG, iB;
    logic        iValid;
    logic [7:0]  oY, oCb, oCr;
    logic        oValid, oDone;
`ifdef LUMA_SUM_EN
    logic [31:0] oLumaSum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rgb2ycbcr_pipe #(.width(W), .height(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .iR       (iR),
        .iG       (iG),
        .iB       (iB),
        .iValid   (iValid),
        .oY       (oY),
        .oCb      (oCb),
        .oCr      (oCr),
        .oValid   (oValid),
`ifdef LUMA_SUM_EN
        .oLumaSum (oLumaSum),
`endif
        .oDone    (oDone)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pixels in flight: index 0 = newest. Output state is what the DUT should show now.
    int         fl_v[2], fl_r[2], fl_g[2], fl_b[2];
    logic       m_v, m_done;
    logic [7:0] m_y, m_cb, m_cr;
    int         m_cnt, m_acc;
    logic [31:0] m_sum;

    function automatic int floor256(int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    function automatic logic [7:0] sat(int x);
        if (x < 0) return 8'd0;
        if (x > 255) return 8'd255;
        return 8'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) fl_v[i] = 0;
        m_v = 0; m_done = 0; m_y = 0; m_cb = 0; m_cr = 0;
        m_cnt = 0; m_acc = 0; m_sum = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge, and
    // return at the next falling edge where the outputs are stable.
    task automatic tick(input logic v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic rst);
        reset = rst; iValid = v; iR = r; iG = g; iB = b;
        if (rst) begin
            model_reset();
        end else begin
            m_done = 0;
            m_v    = fl_v[1][0];
            if (fl_v[1] != 0) begin
                m_y  = sat(floor256(77*fl_r[1] + 150*fl_g[1] + 29*fl_b[1] + 128));
                m_cb = sat(floor256(-43*fl_r[1] - 85*fl_g[1] + 128*fl_b[1] + 128) + 128);
                m_cr = sat(floor256(128*fl_r[1] - 107*fl_g[1] - 21*fl_b[1] + 128) + 128);
                m_acc += int'(m_y);
                m_cnt++;
                if (m_cnt == FRAME) begin
                    m_done = 1; m_cnt = 0; m_sum = 32'(m_acc); m_acc = 0;
                end
            end
            fl_v[1] = fl_v[0]; fl_r[1] = fl_r[0]; fl_g[1] = fl_g[0]; fl_b[1] = fl_b[0];
            fl_v[0] = int'(v); fl_r[0] = int'(r); fl_g[0] = int'(g); fl_b[0] = int'(b);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(1'b1, 8'd9, 8'd9, 8'd9, 1'b1);
        tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_checks++;
        if ({oY, oCb, oCr, oValid, oDone} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got Y=%0d Cb=%0d Cr=%0d v=%b d=%b, want all 0",
                     oY, oCb, oCr, oValid, oDone);
        end
`ifdef LUMA_SUM_EN
        n_checks++;
        if (oLumaSum !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_lumasum got %0d want 0", oLumaSum);
        end
`endif
    endtask

    task automatic test_white_latency();
        for (int t = 0; t < 6; t++) begin
            if (t == 0) tick(1'b1, 8'd255, 8'd255, 8'd255, 1'b0);
            else        tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            n_checks++;
            if (oValid !== (t == 2)) begin
                n_fail++;
                $display("FAIL white_latency t=%0d oValid=%b want %b", t, oValid, (t == 2));
            end
            if (t == 2) begin
                n_checks++;
                if ({oY, oCb, oCr} !== {8'd255, 8'd128, 8'd128}) begin
                    n_fail++;
                    $display("FAIL white_data got %0d/%0d/%0d want 255/128/128", oY, oCb, oCr);
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [23:0] pix [3];
        logic [23:0] want [3];
        pix[0]  = 24'h000000; pix[1]  = 24'hFF0000; pix[2]  = 24'h0000FF;
        want[0] = {8'd0, 8'd128, 8'd128};
        want[1] = {8'd77, 8'd85, 8'd255};
        want[2] = {8'd29, 8'd255, 8'd107};
        for (int t = 0; t < 6; t++) begin
            if (t < 3) tick(1'b1, pix[t][23:16], pix[t][15:8], pix[t][7:0], 1'b0);
            else       tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            if (t >= 2 && t <= 4) begin
                n_checks++;
                if (oValid !== 1'b1 || {oY, oCb, oCr} !== want[t-2]) begin
                    n_fail++;
                    $display("FAIL clamp_px%0d got v=%b %0d/%0d/%0d want v=1 %0d/%0d/%0d",
                             t-2, oValid, oY, oCb, oCr,
                             want[t-2][23:16], want[t-2][15:8], want[t-2][7:0]);
                end
            end
        end
    endtask

    task automatic test_frames();
        int nval, ndone;
        int done_at[$];
        nval = 0; ndone = 0;
        tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        for (int t = 0; t < 36; t++) begin
            if (t < 32 && (t % 2) == 0)
                tick(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            else
                tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            n_checks++;
            if ({oValid, oDone} !== {m_v, m_done}) begin
                n_fail++;
                $display("FAIL frames_ctl t=%0d got v=%b d=%b want v=%b d=%b",
                         t, oValid, oDone, m_v, m_done);
            end
            if (m_v) begin
                n_checks++;
                if ({oY, oCb, oCr} !== {m_y, m_cb, m_cr}) begin
                    n_fail++;
                    $display("FAIL frames_data t=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             t, oY, oCb, oCr, m_y, m_cb, m_cr);
                end
            end
            if (oValid === 1'b1) nval++;
            if (oDone === 1'b1) done_at.push_back(nval);
        end
        n_checks++;
        if (nval != 16) begin
            n_fail++;
            $display("FAIL frames_count got %0d valid outputs want 16", nval);
        end
        n_checks++;
        if (done_at.size() != 2 || done_at[0] != 8 || done_at[1] != 16) begin
            n_fail++;
            $display("FAIL frames_done got %0d pulses (first at %0d) want 2 at 8,16",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
    endtask

    task automatic test_reset_midframe();
        int late_valid, nval, done_pos;
        late_valid = 0; nval = 0; done_pos = -1;
        for (int t = 0; t < 3; t++) tick(1'b1, 8'd200, 8'd10, 8'd50, 1'b0);
        // Reset with a simultaneous valid pixel: reset wins.
        tick(1'b1, 8'd1, 8'd2, 8'd3, 1'b1);
        for (int t = 0; t < 4; t++) begin
            tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            if (oValid !== 1'b0) late_valid++;
        end
        n_checks++;
        if (late_valid != 0) begin
            n_fail++;
            $display("FAIL midreset_flush got %0d stray oValid want 0", late_valid);
        end
        for (int t = 0; t < 11; t++) begin
            if (t < 8) tick(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            else       tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            if (oValid === 1'b1) nval++;
            if (oDone === 1'b1 && done_pos < 0) done_pos = nval;
            if (m_v) begin
                n_checks++;
                if ({oY, oCb, oCr, oDone} !== {m_y, m_cb, m_cr, m_done}) begin
                    n_fail++;
                    $display("FAIL midreset_data t=%0d got %0d/%0d/%0d d=%b want %0d/%0d/%0d d=%b",
                             t, oY, oCb, oCr, oDone, m_y, m_cb, m_cr, m_done);
                end
            end
        end
        n_checks++;
        if (done_pos != 8) begin
            n_fail++;
            $display("FAIL midreset_done got oDone at output %0d want 8", done_pos);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int t = 0; t < 200; t++) begin
            // First 40 cycles continuous valid: frames abut with no gap.
            logic v;
            v = (t < 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
            tick(v, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            n_checks++;
            if ({oValid, oDone} !== {m_v, m_done}) begin
                n_fail++;
                $display("FAIL random_ctl t=%0d got v=%b d=%b want v=%b d=%b",
                         t, oValid, oDone, m_v, m_done);
            end
            if (m_v) begin
                n_checks++;
                if ({oY, oCb, oCr} !== {m_y, m_cb, m_cr}) begin
                    n_fail++;
                    $display("FAIL random_data t=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             t, oY, oCb, oCr, m_y, m_cb, m_cr);
                end
            end
`ifdef LUMA_SUM_EN
            n_checks++;
            if (oLumaSum !== m_sum) begin
                n_fail++;
                $display("FAIL random_lumasum t=%0d got %0d want %0d", t, oLumaSum, m_sum);
            end
`endif
        end
    endtask

`ifdef LUMA_SUM_EN
    task automatic test_luma_sum();
        logic [31:0] want [2];
        int fr;
        want[0] = 32'd2040; want[1] = 32'd0;
        fr = 0;
        tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        for (int t = 0; t < 20; t++) begin
            if (t < 8)       tick(1'b1, 8'd255, 8'd255, 8'd255, 1'b0);
            else if (t < 16) tick(1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
            else             tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            if (oDone === 1'b1 && fr < 2) begin
                n_checks++;
                if (oLumaSum !== want[fr]) begin
                    n_fail++;
                    $display("FAIL luma_sum frame%0d got %0d want %0d", fr, oLumaSum, want[fr]);
                end
                fr++;
            end
        end
        n_checks++;
        if (fr != 2) begin
            n_fail++;
            $display("FAIL luma_frames got %0d oDone pulses want 2", fr);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; iValid = 1'b0; iR = '0; iG = '0; iB = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_white_latency();
        test_clamp();
        test_frames();
        test_reset_midframe();
        test_back_to_back_random();
`ifdef LUMA_SUM_EN
        test_luma_sum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
